// File: rtl/cla_slice_sequencer_if.sv
// cla_slice_sequencer_if
//   Operand/result bundle for cla_slice_sequencer.
//   Request side : in_valid, in_ready, a, b, cin, sub
//   Response side: out_valid, out_ready, sum, cout, overflow
//   master = producer/consumer (drives operands, accepts results)
//   slave  = the sequencer itself
interface cla_slice_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer
//   Multi-cycle WIDTH-bit adder/subtractor that pushes the operands through a
//   single 4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first.
//   The carry between nibbles lives in carry_reg.
// Ports
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : cla_slice_sequencer_if.slave (operand and result handshakes)
//   busy   : high while an operation is in RUN or DONE
// Parameter
//   WIDTH  : operand width, multiple of 4 and >= 4; must match the interface
module cla_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cla_slice_sequencer_if.slave   bus,
  output logic                   busy
);

  localparam int SLICES = WIDTH / 4;
  localparam int IDXW   = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [IDXW-1:0]  idx_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;      // already inverted for subtraction
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             overflow_reg;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] s;
  logic       last_nib;
  logic       overflow_next;

  // Current nibble of each operand
  assign nib_a = a_reg[4*idx_reg +: 4];
  assign nib_b = b_reg[4*idx_reg +: 4];

  // 4-bit carry-lookahead slice: every carry is a flat sum of products of
  // generate/propagate terms and the incoming carry.
  assign g = nib_a & nib_b;
  assign p = nib_a ^ nib_b;

  assign c[0] = carry_reg;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s = p ^ c[3:0];

  assign last_nib = (idx_reg == LAST_IDX);

  // On the final nibble, bit 3 of the slice operands are the operand sign bits
  assign overflow_next = (nib_a[3] == nib_b[3]) && (s[3] != nib_a[3]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.sub ? ~bus.b : bus.b;
            // subtraction forces carry-in to 1 and ignores cin
            carry_reg <= bus.sub | bus.cin;
            idx_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_reg[4*idx_reg +: 4] <= s;
          carry_reg               <= c[4];
          idx_reg                 <= idx_reg + IDXW'(1);
          if (last_nib) begin
            cout_reg     <= c[4];
            overflow_reg <= overflow_next;
            state_reg    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.overflow  = overflow_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// tb_cla_slice_sequencer
//   Directed and random checks of cla_slice_sequencer at WIDTH=16, plus
//   random traffic on WIDTH=4 and WIDTH=32 instances. Expected results are
//   pushed to a queue at each accept and popped when the result is taken.
module tb_cla_slice_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  cla_slice_sequencer_if #(.WIDTH(W)) bus ();

  cla_slice_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, overflow, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   full;
    logic         ov;
    be   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
    ov   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return {full[W], ov, full[W-1:0]};
  endfunction

  logic [W+1:0] sb[$];
  int           op_num = 0;

  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic accept_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    drive_req(a, b, cin, sub);
    for (int t = 0; t < 50 && bus.in_ready !== 1'b1; t++) @(negedge clk);
    check("accept_in_ready", 64'(bus.in_ready), 64'd1);
    sb.push_back(model(a, b, cin, sub));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      check({tag, "_in_ready_run"}, 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic take_result(input string tag);
    logic [W+1:0] exp;
    exp = sb.pop_front();
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_sum"}, 64'(bus.sum), 64'(exp[W-1:0]));
    check({tag, "_overflow"}, 64'(bus.overflow), 64'(exp[W]));
    check({tag, "_cout"}, 64'(bus.cout), 64'(exp[W+1]));
    $display("w16 op %0d %s: sum=%h cout=%b ovf=%b", op_num, tag, bus.sum, bus.cout, bus.overflow);
    op_num++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_after"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Random traffic at other widths
  for (genvar gi = 0; gi < 2; gi++) begin : g_alt
    localparam int GW = (gi == 0) ? 4 : 32;
    localparam int GS = GW / 4;

    logic grst_n;
    logic gbusy;
    logic done = 1'b0;
    logic [GW+1:0] gsb[$];

    cla_slice_sequencer_if #(.WIDTH(GW)) gbus ();

    cla_slice_sequencer #(.WIDTH(GW)) gdut (
      .clk   (clk),
      .rst_n (grst_n),
      .bus   (gbus),
      .busy  (gbusy)
    );

    function automatic logic [GW+1:0] gmodel(input logic [GW-1:0] a, input logic [GW-1:0] b,
                                             input logic cin, input logic sub);
      logic [GW-1:0] be;
      logic [GW:0]   full;
      logic          ov;
      be   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, be} + {{GW{1'b0}}, (sub | cin)};
      ov   = (a[GW-1] == be[GW-1]) && (full[GW-1] != a[GW-1]);
      return {full[GW], ov, full[GW-1:0]};
    endfunction

    initial begin
      logic [GW-1:0] ra;
      logic [GW-1:0] rb;
      logic          rc;
      logic          rs;
      logic [GW+1:0] ex;
      int            lat;
      grst_n         = 1'b0;
      gbus.in_valid  = 1'b0;
      gbus.out_ready = 1'b0;
      gbus.a         = '0;
      gbus.b         = '0;
      gbus.cin       = 1'b0;
      gbus.sub       = 1'b0;
      repeat (2) @(negedge clk);
      grst_n = 1'b1;
      for (int n = 0; n < 200; n++) begin
        ra = GW'($urandom);
        rb = GW'($urandom);
        rc = 1'($urandom);
        rs = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        gbus.in_valid = 1'b1;
        gbus.a        = ra;
        gbus.b        = rb;
        gbus.cin      = rc;
        gbus.sub      = rs;
        lat = 0;
        while (gbus.in_ready !== 1'b1 && lat < 50) begin
          @(negedge clk);
          lat++;
        end
        gsb.push_back(gmodel(ra, rb, rc, rs));
        @(negedge clk);
        gbus.in_valid = 1'b0;
        lat = 0;
        while (gbus.out_valid !== 1'b1 && lat < 50) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("w%0d_latency", GW), 64'(lat), 64'(GS));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ex = gsb.pop_front();
        check($sformatf("w%0d_busy", GW), 64'(gbusy), 64'd1);
        check($sformatf("w%0d_sum", GW), 64'(gbus.sum), 64'(ex[GW-1:0]));
        check($sformatf("w%0d_overflow", GW), 64'(gbus.overflow), 64'(ex[GW]));
        check($sformatf("w%0d_cout", GW), 64'(gbus.cout), 64'(ex[GW+1]));
        $display("w%0d op %0d: a=%h b=%h sub=%b sum=%h cout=%b ovf=%b",
                 GW, n, ra, rb, rs, gbus.sum, gbus.cout, gbus.overflow);
        gbus.out_ready = 1'b1;
        @(negedge clk);
        gbus.out_ready = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    logic [W+1:0] held;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Plain add
    accept_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_out("add", 4);
    check("add_const", 64'(bus.sum), 64'h5555);
    take_result("add");

    // Carry ripples through every slice
    accept_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_out("ripple", 4);
    check("ripple_const", 64'({bus.cout, bus.sum}), 64'h10000);
    take_result("ripple");

    // Signed overflow via cin
    accept_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    wait_out("ovf", 4);
    check("ovf_const", 64'({bus.cout, bus.overflow, bus.sum}), 64'h18000);
    take_result("ovf");

    // Subtract with borrow, cin ignored
    accept_op(16'h0005, 16'h0007, 1'b1, 1'b1);
    wait_out("sub_borrow", 4);
    check("sub_borrow_const", 64'({bus.cout, bus.overflow, bus.sum}), 64'h0FFFE);
    take_result("sub_borrow");

    // Subtract with signed overflow
    accept_op(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait_out("sub_ovf", 4);
    check("sub_ovf_const", 64'({bus.cout, bus.overflow, bus.sum}), 64'h37FFF);
    take_result("sub_ovf");

    // Backpressure: outputs frozen, second request held off until IDLE
    accept_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    wait_out("bp1", 4);
    held = sb[0];
    drive_req(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_sum_frozen", 64'(bus.sum), 64'h1010);
      check("bp_flags_frozen", 64'({bus.cout, bus.overflow}), 64'(held[W+1:W]));
    end
    take_result("bp1");
    accept_op(16'hAAAA, 16'h5555, 1'b0, 1'b1);
    wait_out("bp2", 4);
    check("bp2_const", 64'({bus.cout, bus.overflow, bus.sum}), 64'h35555);
    take_result("bp2");

    // Reset during RUN aborts the operation
    accept_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_sum", 64'(bus.sum), 64'd0);
    check("abort_cout", 64'(bus.cout), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    check("abort_no_result", 64'(bus.out_valid), 64'd0);
    accept_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_out("post_rst", 4);
    check("post_rst_const", 64'(bus.sum), 64'h0100);
    take_result("post_rst");

    // Random traffic
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      accept_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      wait_out("rnd", 4);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      take_result("rnd");
    end

    for (int t = 0; t < 20000 && !(g_alt[0].done && g_alt[1].done); t++) @(negedge clk);
    check("alt_widths_done", 64'({g_alt[1].done, g_alt[0].done}), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
